mux_n_sel: RTL and testbench

Parametrised, registered N-channel by W-bit selector for the processor datapath, the successor to the fixed 4:1 single-bit mux. It forwards one word from CHANNELS valid/ready input channels into a one-entry output register. The source is either an explicit select value or a round-robin scan. It sits between producer stages (register file, ALU, immediate, memory read) and any consumer that may stall.

---
 rtl/mux_n_sel_pkg.sv | 12 +
 rtl/mux_n_sel_if.sv | 32 +++
 rtl/mux_n_sel_rr_arbiter.sv | 30 +++
 rtl/mux_n_sel.sv | 121 ++++++++++++
 tb/tb_mux_n_sel.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_n_sel_pkg.sv
// Shared constants and helpers for the N-channel registered selector.
package mux_n_pkg;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Index width for n channels; never below one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_sel_if.sv
// Bus bundle for mux_n_sel: per-channel inputs, source control and the output register port.
interface mux_n_sel_if
    import mux_n_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = sel_width(CHANNELS);

    // A word moves on a rising clk edge exactly when valid and ready are both high;
    // valid never depends on ready, and ready never depends on data.
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          select;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    modport master (
        output in_valid, in_data, mode, select, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, mode, select, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/mux_n_sel_rr_arbiter.sv
// Round-robin picker: first requesting channel at or after ptr_i, wrapping modulo CHANNELS.
module rr_arbiter
    import mux_n_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SEL_W-1:0]    ptr_i,
    output logic [SEL_W-1:0]    gnt_idx_o,
    output logic                gnt_v_o
);

    always_comb begin
        int c;
        c         = 0;
        gnt_v_o   = 1'b0;
        gnt_idx_o = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            // ptr_i is always below CHANNELS, so one subtraction wraps.
            c = int'(ptr_i) + k;
            if (c >= CHANNELS) c = c - CHANNELS;
            if (!gnt_v_o && req_i[c]) begin
                gnt_v_o   = 1'b1;
                gnt_idx_o = SEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/mux_n_sel.sv
// Registered N:1 word selector with explicit or round-robin source choice.
// Round-robin mode exists only when MUX_N_SEL_RR_EN is defined.
module mux_n_sel
    import mux_n_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input logic        clk,
    input logic        rst,
    mux_n_sel_if.slave bus
);
    localparam int SEL_W = sel_width(CHANNELS);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;

    logic             can_accept, sel_in_range, sel_valid, rr_mode;
    logic             gnt_v, rdy_hit, xfer;
    logic [SEL_W-1:0] gnt_idx, arb_idx;
    logic             arb_v;
    logic [WIDTH-1:0] gnt_word;
    logic [CHANNELS-1:0] in_ready_c;

    assign can_accept   = !out_valid_q || bus.out_ready;
    assign sel_in_range = int'(bus.select) < CHANNELS;

`ifdef MUX_N_SEL_RR_EN
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req_i     (bus.in_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (arb_idx),
        .gnt_v_o   (arb_v)
    );

    assign rr_mode = (bus.mode == MODE_RR);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer && rr_mode)
            rr_ptr_d = (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`else
    logic unused_mode;
    assign unused_mode = bus.mode;
    assign rr_mode     = MODE_SELECT;
    assign arb_idx     = '0;
    assign arb_v       = 1'b0;
`endif

    always_comb begin
        sel_valid = 1'b0;
        for (int c = 0; c < CHANNELS; c++)
            if (int'(bus.select) == c) sel_valid = bus.in_valid[c];
    end

    // Explicit mode offers ready on the selected channel even without valid.
    always_comb begin
        gnt_idx = bus.select;
        gnt_v   = sel_in_range && sel_valid;
        rdy_hit = sel_in_range;
        if (rr_mode) begin
            gnt_idx = arb_idx;
            gnt_v   = arb_v;
            rdy_hit = arb_v;
        end
    end

    always_comb begin
        in_ready_c = '0;
        gnt_word   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            in_ready_c[c] = !rst && can_accept && rdy_hit && (int'(gnt_idx) == c);
            if (int'(gnt_idx) == c) gnt_word = bus.in_data[c*WIDTH +: WIDTH];
        end
    end

    assign xfer = can_accept && gnt_v;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_word;
            out_sel_d   = gnt_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_n_sel.sv
// Directed bench for mux_n_sel: a 4-channel and a 3-channel instance, 8-bit words.
module tb_mux_n_sel;

    logic clk;
    logic rst;

    mux_n_sel_if #(.WIDTH(8), .CHANNELS(4)) b4 ();
    mux_n_sel_if #(.WIDTH(8), .CHANNELS(3)) b3 ();

    mux_n_sel #(.WIDTH(8), .CHANNELS(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    mux_n_sel #(.WIDTH(8), .CHANNELS(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    int n_cmp  = 0;
    int n_fail = 0;

    logic [9:0] exp4_q[$];
    logic [9:0] exp3_q[$];
    logic [9:0] e4, e3;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, expected finish");
        $fatal(1);
    end

    function automatic logic [9:0] mk(input int s, input int d);
        return {s[1:0], d[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv4(input logic [3:0] v, input int sel, input logic m, input logic ordy);
        b4.in_valid  = v;
        b4.select    = 2'(sel);
        b4.mode      = m;
        b4.out_ready = ordy;
    endtask

    task automatic drv3(input logic [2:0] v, input int sel, input logic m, input logic ordy);
        b3.in_valid  = v;
        b3.select    = 2'(sel);
        b3.mode      = m;
        b3.out_ready = ordy;
    endtask

    // scoreboard monitors: a word is consumed when valid and ready meet at the edge
    always @(negedge clk) begin
        if (!rst && b4.out_valid && b4.out_ready) begin
            n_cmp++;
            if (exp4_q.size() == 0) begin
                n_fail++;
                $display("FAIL out4_unexpected: got sel=%0d data=%h, expected no word", b4.out_sel, b4.out_data);
            end else begin
                e4 = exp4_q.pop_front();
                if ({b4.out_sel, b4.out_data} !== e4) begin
                    n_fail++;
                    $display("FAIL out4_word: got sel=%0d data=%h expected sel=%0d data=%h",
                             b4.out_sel, b4.out_data, e4[9:8], e4[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b3.out_valid && b3.out_ready) begin
            n_cmp++;
            if (exp3_q.size() == 0) begin
                n_fail++;
                $display("FAIL out3_unexpected: got sel=%0d data=%h, expected no word", b3.out_sel, b3.out_data);
            end else begin
                e3 = exp3_q.pop_front();
                if ({b3.out_sel, b3.out_data} !== e3) begin
                    n_fail++;
                    $display("FAIL out3_word: got sel=%0d data=%h expected sel=%0d data=%h",
                             b3.out_sel, b3.out_data, e3[9:8], e3[7:0]);
                end
            end
        end
    end

    initial begin
        int rr_a[5];
        int rr_b[2];
        int rr3[4];
        rr_a = '{0, 1, 2, 3, 0};
        rr_b = '{3, 0};
        rr3  = '{0, 1, 2, 0};

        rst = 1'b1;
        b4.in_data = {8'h33, 8'hA5, 8'h22, 8'h11};
        b3.in_data = {8'h72, 8'h71, 8'h70};
        drv4(4'b1111, 0, 1'b0, 1'b1);
        drv3(3'b000, 0, 1'b0, 1'b0);
        #2;
        chk("rst_in_ready", 32'(b4.in_ready), 32'h0);
        chk("rst_out_valid", 32'(b4.out_valid), 32'h0);
        chk("rst_out_data", 32'(b4.out_data), 32'h0);
        chk("rst_out_sel", 32'(b4.out_sel), 32'h0);
        drv4(4'b0000, 0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;

        // explicit select, channel 2
        drv4(4'b0100, 2, 1'b0, 1'b1);
        exp4_q.push_back(mk(2, 8'hA5));
        @(negedge clk);
        chk("sel_in_ready", 32'(b4.in_ready), 32'b0100);
        step();
        b4.in_valid = 4'b0000;
        step();

        // backpressure: hold a word for three cycles, then refill on the draining edge
        b4.in_data = {8'h33, 8'hA5, 8'h3C, 8'h11};
        drv4(4'b0010, 1, 1'b0, 1'b0);
        exp4_q.push_back(mk(1, 8'h3C));
        @(negedge clk);
        chk("bp_first_ready", 32'(b4.in_ready), 32'b0010);
        step();
        b4.in_data = {8'h33, 8'hA5, 8'h5A, 8'h11};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_ready", 32'(b4.in_ready), 32'h0);
            chk("bp_stall_data", 32'(b4.out_data), 32'h3C);
            chk("bp_stall_sel", 32'(b4.out_sel), 32'h1);
            step();
        end
        b4.out_ready = 1'b1;
        exp4_q.push_back(mk(1, 8'h5A));
        @(negedge clk);
        chk("bp_release_ready", 32'(b4.in_ready), 32'b0010);
        step();
        b4.in_valid = 4'b0000;
        @(negedge clk);
        chk("bp_no_bubble", 32'(b4.out_valid), 32'h1);
        step();
        step();

        // round-robin request on the 4-channel instance
        b4.in_data = {8'h43, 8'h42, 8'h41, 8'h40};
`ifdef MUX_N_SEL_RR_EN
        drv4(4'b1111, 0, 1'b1, 1'b1);
        foreach (rr_a[i]) begin
            exp4_q.push_back(mk(rr_a[i], 8'h40 + rr_a[i]));
            @(negedge clk);
            chk("rr_all_ready", 32'(b4.in_ready), 32'(1) << rr_a[i]);
            step();
        end
        b4.in_valid = 4'b1001;
        foreach (rr_b[i]) begin
            exp4_q.push_back(mk(rr_b[i], 8'h40 + rr_b[i]));
            @(negedge clk);
            chk("rr_1001_ready", 32'(b4.in_ready), 32'(1) << rr_b[i]);
            step();
        end
`else
        drv4(4'b1111, 1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp4_q.push_back(mk(1, 8'h41));
            @(negedge clk);
            chk("norr_ready", 32'(b4.in_ready), 32'b0010);
            step();
        end
`endif
        drv4(4'b0000, 0, 1'b0, 1'b1);
        step();
        step();

        // three channels: out-of-range select, then wrap
        drv3(3'b111, 0, 1'b0, 1'b1);
        exp3_q.push_back(mk(0, 8'h70));
        @(negedge clk);
        chk("c3_sel0_ready", 32'(b3.in_ready), 32'b001);
        step();
        b3.select = 2'd3;
        @(negedge clk);
        chk("c3_sel3_ready", 32'(b3.in_ready), 32'h0);
        step();
        @(negedge clk);
        chk("c3_drain_valid", 32'(b3.out_valid), 32'h0);
        chk("c3_drain_data", 32'(b3.out_data), 32'h70);
        chk("c3_drain_sel", 32'(b3.out_sel), 32'h0);
`ifdef MUX_N_SEL_RR_EN
        b3.mode = 1'b1;
        foreach (rr3[i]) begin
            exp3_q.push_back(mk(rr3[i], 8'h70 + rr3[i]));
            @(negedge clk);
            chk("c3_rr_ready", 32'(b3.in_ready), 32'(1) << rr3[i]);
            step();
        end
`else
        b3.mode = 1'b1;
        @(negedge clk);
        chk("c3_norr_sel3_ready", 32'(b3.in_ready), 32'h0);
        step();
        b3.select = 2'd2;
        for (int i = 0; i < 2; i++) begin
            exp3_q.push_back(mk(2, 8'h72));
            @(negedge clk);
            chk("c3_norr_ready", 32'(b3.in_ready), 32'b100);
            step();
        end
`endif
        drv3(3'b000, 0, 1'b0, 1'b1);
        step();
        step();

        // asynchronous reset with a held word
        b4.in_data = {8'h43, 8'h42, 8'h41, 8'h99};
        drv4(4'b0001, 0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        chk("ar_loaded_valid", 32'(b4.out_valid), 32'h1);
        chk("ar_loaded_data", 32'(b4.out_data), 32'h99);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(b4.out_valid), 32'h0);
        chk("ar_out_data", 32'(b4.out_data), 32'h0);
        chk("ar_out_sel", 32'(b4.out_sel), 32'h0);
        chk("ar_in_ready", 32'(b4.in_ready), 32'h0);
        step();
        b4.out_ready = 1'b1;
        #1;
        chk("ar_in_ready_held", 32'(b4.in_ready), 32'h0);
        rst = 1'b0;
        exp4_q.push_back(mk(0, 8'h99));
        @(negedge clk);
        chk("ar_release_ready", 32'(b4.in_ready), 32'b0001);
        step();
        b4.in_valid = 4'b0000;
        step();
        step();

        chk("q4_empty", 32'(exp4_q.size()), 32'h0);
        chk("q3_empty", 32'(exp3_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
